alu_intr_ctrl: RTL and testbench
================================

ALU_INTR_CTRL -- requirements
Module: alu_intr_ctrl

Interface
REQ-001 Parameter NSRC, default 4: number of interrupt event sources (1..8).
REQ-002 Parameter HOLDOFF_RST, default 2: reset value of HOLDOFF register.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 src_evt  input  NSRC  event pulses from ALU (bit0 done, bit1 overflow, bit2 div_by_zero, bit3 illegal_op); each high cycle is one event.
REQ-006 reg_wr  input  1  register write strobe.
REQ-007 reg_rd  input  1  register read strobe.
REQ-008 reg_addr  input  3  register select.
REQ-009 reg_wdata  input  32  write data.
REQ-010 reg_rdata  output  32  read data, valid with reg_rvalid.
REQ-011 reg_rvalid  output  1  one-cycle pulse, one cycle after reg_rd.
REQ-012 irq  output  1  level interrupt to CPU / intr_if.IRQ, registered.
REQ-013 irq_id  output  3  index of highest-priority active source, registered.

Function
REQ-014 Register map SHALL be: 0 ENABLE (RW, NSRC bits), 1 PENDING (read raw sticky bits, write-1-to-clear), 2 STATUS (RO, PENDING & ENABLE), 3 ID (RO, irq_id), 4 HOLDOFF (RW, 8 bits), 5 EVT_CNT (RO 16-bit saturating event count; any write clears).
REQ-015 Unmapped addresses SHALL read 0; writes to them and to RO registers SHALL be ignored; unused upper bits read 0.
REQ-016 PENDING[i] SHALL set on the cycle after src_evt[i]=1, regardless of ENABLE[i].
REQ-017 Same-cycle src_evt[i]=1 and W1C of bit i: set wins, bit stays 1.
REQ-018 EVT_CNT SHALL add popcount(src_evt) per cycle, saturating at 0xFFFF; same-cycle write-clear and events: count = popcount of that cycle's events.
REQ-019 irq_id SHALL be lowest index i with STATUS[i]=1; 0 when STATUS=0.
REQ-020 Read latency SHALL be 1 cycle; read returns register value before any same-cycle write.
REQ-021 FSM states IDLE, ASSERT, HOLDOFF; irq=1 only in ASSERT.
REQ-022 IDLE -> ASSERT when STATUS != 0; irq rises the following cycle.
REQ-023 ASSERT -> HOLDOFF when STATUS == 0 (cleared or disabled); counter loads HOLDOFF value; if HOLDOFF==0 go ASSERT -> IDLE directly.
REQ-024 HOLDOFF: counter decrements each cycle, irq=0; at counter==1 go to IDLE; new events during HOLDOFF are latched in PENDING but do not raise irq.
REQ-025 Guarantee: irq low for at least HOLDOFF+1 cycles between assertions, so every assertion is a distinct posedge.
REQ-026 Writing HOLDOFF while in HOLDOFF state SHALL not affect the running counter.

Reset
REQ-027 While rst=1: ENABLE=0, PENDING=0, EVT_CNT=0, HOLDOFF=HOLDOFF_RST, FSM=IDLE, irq=0, irq_id=0, reg_rdata=0, reg_rvalid=0.
REQ-028 Reset asserted mid-ASSERT or mid-HOLDOFF SHALL drop irq asynchronously and discard all pending events.

Structure
REQ-029 Shared package alu_intr_pkg SHALL hold register address constants, source index constants and the FSM state enum.
REQ-030 One sub-module alu_intr_prio_enc (combinational lowest-index priority encoder, NSRC in, id + valid out).

Verification
REQ-031 ENABLE=0xF, pulse src_evt=0x2 -> PENDING=0x2, irq=1 two cycles after pulse, irq_id=1.
REQ-032 src_evt=0x6 same cycle -> irq_id=1; W1C 0x2 -> irq stays 1, irq_id=2; W1C 0x4 -> irq falls, low for 3 cycles (HOLDOFF=2).
REQ-033 ENABLE=0x0, src_evt=0x8 -> PENDING=0x8, irq stays 0; then ENABLE=0x8 -> irq rises.
REQ-034 HOLDOFF=5, clear while src_evt=0x1 pulses during holdoff -> irq low exactly 6 cycles, then reasserts, irq_id=0.
REQ-035 Same-cycle src_evt=0x1 and W1C 0x1 -> PENDING[0]=1, irq remains/becomes 1.
REQ-036 70000 events on bit0 -> EVT_CNT=0xFFFF; assert rst while irq=1 -> irq=0 immediately, all registers at reset values.

Source files
------------

// File: rtl/alu_intr_pkg.sv
// Shared definitions for the ALU interrupt controller: register map,
// ALU event source indices, FSM state type and an event popcount helper.
package alu_intr_pkg;

  // register map (reg_addr)
  localparam logic [2:0] ADDR_ENABLE  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_ID      = 3'd3;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd4;
  localparam logic [2:0] ADDR_EVT_CNT = 3'd5;

  // ALU event source bit positions in src_evt
  localparam int SRC_DONE        = 0;
  localparam int SRC_OVERFLOW    = 1;
  localparam int SRC_DIV_BY_ZERO = 2;
  localparam int SRC_ILLEGAL_OP  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // number of set bits in an (up to) 8-source event vector
  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/alu_intr_ctrl_if.sv
// Bus bundle for the ALU interrupt controller.
//   src_evt           ALU event pulses into the controller
//   reg_wr/rd/addr/wdata  register access request
//   reg_rdata/rvalid  read response, one cycle after reg_rd
//   irq/irq_id        registered interrupt level and source index
// master = driver side (ALU + CPU), slave = controller side.
interface alu_intr_ctrl_if #(parameter int NSRC = 4);
  logic [NSRC-1:0] src_evt;
  logic            reg_wr;
  logic            reg_rd;
  logic [2:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            reg_rvalid;
  logic            irq;
  logic [2:0]      irq_id;

  modport master (
    output src_evt, reg_wr, reg_rd, reg_addr, reg_wdata,
    input  reg_rdata, reg_rvalid, irq, irq_id
  );

  modport slave (
    input  src_evt, reg_wr, reg_rd, reg_addr, reg_wdata,
    output reg_rdata, reg_rvalid, irq, irq_id
  );
endinterface

// File: rtl/alu_intr_prio_enc.sv
// Combinational lowest-index priority encoder.
//   vec  NSRC-bit request vector
//   id   index of the lowest set bit (0 when vec is empty)
//   vld  any bit of vec set
module alu_intr_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] vec,
  output logic [2:0]      id,
  output logic            vld
);

  // scan high to low so the lowest set index is the last assignment
  always_comb begin
    id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) id = 3'(i);
    end
  end

  assign vld = |vec;

endmodule

// File: rtl/alu_intr_ctrl.sv
// ALU interrupt controller: latches ALU event pulses into sticky PENDING
// bits, masks them with ENABLE, and drives a level irq with a programmable
// holdoff gap so every assertion is a distinct rising edge.
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  alu_intr_ctrl_if.slave: src_evt, register port, irq/irq_id
module alu_intr_ctrl
  import alu_intr_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int HOLDOFF_RST = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_intr_ctrl_if.slave     bus
);

  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] status;
  logic [7:0]      holdoff_q;
  logic [7:0]      hold_cnt_q;
  logic [15:0]     evt_cnt_q;
  logic            irq_q;
  logic [2:0]      irq_id_q;
  logic [31:0]     rdata_q;
  logic            rvalid_q;
  state_e          state_q, state_d;
  logic            hold_load;

  logic [2:0]      enc_id;
  logic            enc_vld;

  logic            wr_enable, wr_pending, wr_holdoff, wr_evt_cnt;
  logic [3:0]      evt_pop;
  logic [16:0]     cnt_sum;
  logic [15:0]     cnt_sat;
  logic [31:0]     rd_val;

  assign status = pend_q & enable_q;

  alu_intr_prio_enc #(.NSRC(NSRC)) u_prio (
    .vec (status),
    .id  (enc_id),
    .vld (enc_vld)
  );

  assign wr_enable  = bus.reg_wr && (bus.reg_addr == ADDR_ENABLE);
  assign wr_pending = bus.reg_wr && (bus.reg_addr == ADDR_PENDING);
  assign wr_holdoff = bus.reg_wr && (bus.reg_addr == ADDR_HOLDOFF);
  assign wr_evt_cnt = bus.reg_wr && (bus.reg_addr == ADDR_EVT_CNT);

  // event counter: 17-bit sum so the carry marks saturation
  assign evt_pop = popcnt8(8'(bus.src_evt));
  assign cnt_sum = {1'b0, evt_cnt_q} + 17'(evt_pop);
  assign cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // config registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q  <= '0;
      holdoff_q <= 8'(HOLDOFF_RST);
    end else begin
      if (wr_enable)  enable_q  <= bus.reg_wdata[NSRC-1:0];
      if (wr_holdoff) holdoff_q <= bus.reg_wdata[7:0];
    end
  end

  // sticky pending: clear applied first, so a same-cycle event wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else if (wr_pending) begin
      pend_q <= (pend_q & ~bus.reg_wdata[NSRC-1:0]) | bus.src_evt;
    end else begin
      pend_q <= pend_q | bus.src_evt;
    end
  end

  // any write clears; events of the clearing cycle still count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             evt_cnt_q <= '0;
    else if (wr_evt_cnt) evt_cnt_q <= 16'(evt_pop);
    else                 evt_cnt_q <= cnt_sat;
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    hold_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!enc_vld) begin
          if (holdoff_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_HOLDOFF;
            hold_load = 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q <= 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // counter snapshots HOLDOFF only on entry, so later writes don't disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (hold_load) begin
      hold_cnt_q <= holdoff_q;
    end else if (state_q == ST_HOLDOFF && hold_cnt_q != 8'd0) begin
      hold_cnt_q <= hold_cnt_q - 8'd1;
    end
  end

  // irq mirrors the ASSERT state from a flop; id tracks STATUS each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      irq_q    <= (state_d == ST_ASSERT);
      irq_id_q <= enc_id;
    end
  end

  // read mux sees register values before any same-cycle write
  always_comb begin
    rd_val = '0;
    case (bus.reg_addr)
      ADDR_ENABLE:  rd_val = 32'(enable_q);
      ADDR_PENDING: rd_val = 32'(pend_q);
      ADDR_STATUS:  rd_val = 32'(status);
      ADDR_ID:      rd_val = 32'(irq_id_q);
      ADDR_HOLDOFF: rd_val = 32'(holdoff_q);
      ADDR_EVT_CNT: rd_val = 32'(evt_cnt_q);
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.reg_rd;
      rdata_q  <= bus.reg_rd ? rd_val : 32'd0;
    end
  end

  assign bus.irq        = irq_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.reg_rdata  = rdata_q;
  assign bus.reg_rvalid = rvalid_q;

endmodule

// File: tb/tb_alu_intr_ctrl.sv
// Bench for alu_intr_ctrl: directed scenarios plus random traffic, with
// register contents predicted by a small arithmetic model.
module tb_alu_intr_ctrl;
  localparam int NSRC = 4;
  localparam int MASK = (1 << NSRC) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_intr_ctrl_if #(.NSRC(NSRC)) bus ();

  alu_intr_ctrl #(.NSRC(NSRC), .HOLDOFF_RST(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  // reference model state
  int m_en, m_pend, m_cnt, m_hold, m_id, prev_stat;

  function automatic int lowest(input int v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int model_read(input int addr);
    case (addr)
      0: return m_en;
      1: return m_pend;
      2: return m_pend & m_en;
      3: return m_id;
      4: return m_hold;
      5: return m_cnt;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_cnt = 0; m_hold = 2; m_id = 0; prev_stat = 0;
  endtask

  // one clock cycle of stimulus; model advances and outputs are checked
  task automatic cyc(input int evt, input bit wr, input int addr, input int wdata, input bit rd);
    int exp_rd, pc;
    bus.src_evt   = NSRC'(evt);
    bus.reg_wr    = wr;
    bus.reg_rd    = rd;
    bus.reg_addr  = 3'(addr);
    bus.reg_wdata = 32'(wdata);
    exp_rd    = model_read(addr);
    prev_stat = m_pend & m_en;
    tick();
    m_id = lowest(prev_stat);
    pc   = $countones(evt & MASK);
    if (wr) begin
      case (addr)
        0: m_en   = wdata & MASK;
        1: m_pend = m_pend & ~wdata;
        4: m_hold = wdata & 'hFF;
        default: ;
      endcase
    end
    m_pend = (m_pend | evt) & MASK;
    if (wr && addr == 5) m_cnt = pc;
    else                 m_cnt = (m_cnt + pc > 65535) ? 65535 : m_cnt + pc;
    bus.src_evt = '0; bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
    chk("rvalid", bus.reg_rvalid, rd);
    if (rd) chk($sformatf("rdata_a%0d", addr), bus.reg_rdata, exp_rd);
    chk("irq_id", bus.irq_id, m_id);
    chk("irq_without_status", (bus.irq && prev_stat == 0), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // counts irq-low cycles after a clear; optional HOLDOFF write mid-holdoff
  task automatic gap(input int evt, input bit hw, input int hv, output int n);
    n = 0;
    cyc(evt, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      if (bus.irq) break;
      n++;
      if (i == 0 && hw) cyc(0, 1, 4, hv, 0);
      else              cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_irq"},    bus.irq, 0);
    chk({tag, "_irq_id"}, bus.irq_id, 0);
    chk({tag, "_rvalid"}, bus.reg_rvalid, 0);
    chk({tag, "_rdata"},  bus.reg_rdata, 0);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    bus.src_evt = '0; bus.reg_wr = 1'b0; bus.reg_rd = 1'b0;
    bus.reg_addr = '0; bus.reg_wdata = '0;
    model_reset();
    #2;
    check_reset_outputs("rst0");
    tick(); tick();
    rst = 1'b0;

    // reset values of every address, RO/unmapped writes ignored
    for (int a = 0; a < 8; a++) cyc(0, 0, a, 0, 1);
    cyc(0, 1, 2, 'hFFFF, 0);
    cyc(0, 1, 3, 'hFFFF, 0);
    cyc(0, 1, 6, 'hFFFF, 0);
    cyc(0, 1, 7, 'hFFFF, 0);
    for (int a = 0; a < 8; a++) cyc(0, 0, a, 0, 1);

    // single overflow event
    cyc(0, 1, 0, 'hF, 0);
    cyc(2, 0, 0, 0, 0);
    chk("031_irq_early", bus.irq, 0);
    cyc(0, 0, 0, 0, 0);
    chk("031_irq", bus.irq, 1);
    chk("031_id", bus.irq_id, 1);
    cyc(0, 0, 1, 0, 1);
    chk("031_pend", bus.reg_rdata, 2);
    cyc(0, 1, 1, 'hF, 0);
    idle(10);

    // two sources, cleared one at a time
    cyc(6, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("032_irq_a", bus.irq, 1);
    chk("032_id_a", bus.irq_id, 1);
    cyc(0, 1, 1, 2, 0);
    cyc(0, 0, 0, 0, 0);
    chk("032_irq_b", bus.irq, 1);
    chk("032_id_b", bus.irq_id, 2);
    cyc(0, 1, 1, 4, 0);
    chk("032_irq_c", bus.irq, 1);
    gap(1, 0, 0, n);
    chk("032_gap", n, 3);
    chk("032_reassert_id", bus.irq_id, 0);

    // HOLDOFF written mid-holdoff leaves the running gap alone
    cyc(0, 1, 1, 1, 0);
    gap(1, 1, 9, n);
    chk("026_gap", n, 3);
    cyc(0, 0, 4, 0, 1);
    chk("026_holdoff_reg", bus.reg_rdata, 9);

    // HOLDOFF=5, event during the gap
    cyc(0, 1, 4, 5, 0);
    cyc(0, 1, 1, 1, 0);
    gap(1, 0, 0, n);
    chk("034_gap", n, 6);
    chk("034_irq", bus.irq, 1);
    chk("034_id", bus.irq_id, 0);

    // HOLDOFF=0: back-to-back reassert after one low cycle
    cyc(0, 1, 4, 0, 0);
    cyc(0, 1, 1, 1, 0);
    gap(1, 0, 0, n);
    chk("holdoff0_gap", n, 1);

    // masked source
    cyc(0, 1, 4, 2, 0);
    cyc(0, 1, 1, 'hF, 0);
    idle(12);
    cyc(0, 1, 0, 0, 0);
    cyc(8, 0, 0, 0, 0);
    idle(3);
    chk("033_irq_masked", bus.irq, 0);
    cyc(0, 0, 1, 0, 1);
    chk("033_pend", bus.reg_rdata, 8);
    cyc(0, 1, 0, 8, 0);
    chk("033_irq_pre", bus.irq, 0);
    cyc(0, 0, 0, 0, 0);
    chk("033_irq", bus.irq, 1);
    chk("033_id", bus.irq_id, 3);

    // event and W1C of the same bit in one cycle
    cyc(0, 1, 0, 'hF, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 1);
    chk("035_pend", bus.reg_rdata, 9);
    chk("035_irq", bus.irq, 1);
    cyc(0, 1, 1, 'hF, 0);
    idle(8);
    cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("035_irq_rise", bus.irq, 1);

    // counter clear together with events
    cyc(5, 1, 5, 0, 0);
    cyc(0, 0, 5, 0, 1);
    chk("018_cnt", bus.reg_rdata, 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int evt, a, wd;
      bit w, r;
      evt = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) evt = 0;
      w  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 1) == 0);
      a  = $urandom_range(0, 7);
      wd = int'($urandom);
      if (a == 4) wd = wd & 7;
      cyc(evt, w, a, wd, r);
    end

    // saturation, then reset while asserted
    cyc(0, 1, 0, 'hF, 0);
    cyc(0, 1, 5, 0, 0);
    for (int i = 0; i < 70000; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 5, 0, 1);
    chk("036_sat", bus.reg_rdata, 'hFFFF);
    chk("036_irq_before_rst", bus.irq, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("036_rst");
    tick(); tick();
    check_reset_outputs("036_rst_hold");
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < 8; a++) cyc(0, 0, a, 0, 1);
    chk("036_irq_after", bus.irq, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
